// File: rtl/counter_cfg_sequencer.sv
// counter_cfg_sequencer
//
// Purpose:
//   Bus-master controller for the 8-bit up/down counter and its PLR/ULR/LLR/CCR
//   register file. A host request latches four register values. The sequencer
//   first validates them. It then writes all four registers over the
//   ncs/nwr/a1/a0/data bus and checks the counter's err flag. Next it pulses
//   start and supervises the run until the counter reports end-of-cycle or the
//   run times out. The result goes back to the host as a one-cycle done or fail
//   pulse, and fail carries a reason code.
//
// Ports:
//   clk        in   1  single clock, all logic on posedge
//   reset      in   1  asynchronous, active-low
//   req        in   1  host run request, only looked at in IDLE
//   abort      in   1  host abort, honoured in every active state
//   plr_in     in   8  preload value, latched when req is accepted
//   ulr_in     in   8  upper limit, latched when req is accepted
//   llr_in     in   8  lower limit, latched when req is accepted
//   ccr_in     in   8  cycle count, latched when req is accepted
//   cnt_err    in   1  counter err flag
//   cnt_ec     in   1  counter end-of-cycle flag
//   ncs        out  1  counter chip select, active-low
//   nwr        out  1  counter write strobe, active-low
//   nrd        out  1  counter read strobe, permanently inactive
//   a1, a0     out  1  register address
//   bus_dout   out  8  write data toward counter din
//   bus_oe     out  1  drive enable for bus_dout
//   start      out  1  counter start
//   busy       out  1  high whenever the sequencer is not idle
//   done       out  1  one-cycle pulse on a successful run
//   fail       out  1  one-cycle pulse on failure
//   fail_code  out  2  00 abort, 01 range/err, 10 timeout, 11 CCR==0

module counter_cfg_sequencer #(
    parameter int START_W = 1,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       abort,
    input  logic [7:0] plr_in,
    input  logic [7:0] ulr_in,
    input  logic [7:0] llr_in,
    input  logic [7:0] ccr_in,
    input  logic       cnt_err,
    input  logic       cnt_ec,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       a1,
    output logic       a0,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    output logic       start,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] fail_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_VALID, S_WSETUP, S_WSTROBE, S_CHECK,
        S_START, S_RUN, S_DONE, S_FAIL
    } state_t;

    localparam logic [1:0] CODE_ABORT   = 2'b00;
    localparam logic [1:0] CODE_RANGE   = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_CCR0    = 2'b11;

    state_t          state_q, state_d;
    logic [7:0]      plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      start_cnt_q, start_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            ncs_q, ncs_d, nwr_q, nwr_d, oe_q, oe_d, start_q, start_d;
    logic [1:0]      addr_q, addr_d, code_q, code_d;
    logic [7:0]      dout_q, dout_d, wr_data;
    logic            busy_q, busy_d, done_q, done_d, fail_q, fail_d;

    // Next-state logic. All bus outputs are derived from the next state, so
    // each output is registered together with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        plr_d       = plr_q;
        ulr_d       = ulr_q;
        llr_d       = llr_q;
        ccr_d       = ccr_q;
        idx_d       = idx_q;
        start_cnt_d = start_cnt_q;
        to_cnt_d    = to_cnt_q;
        code_d      = code_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    plr_d   = plr_in;
                    ulr_d   = ulr_in;
                    llr_d   = llr_in;
                    ccr_d   = ccr_in;
                    code_d  = CODE_ABORT;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (abort) begin
                    state_d = S_FAIL;
                    code_d  = CODE_ABORT;
                end else if (ccr_q == 8'd0) begin
                    state_d = S_FAIL;
                    code_d  = CODE_CCR0;
                end else if ((plr_q < llr_q) || (plr_q > ulr_q)) begin
                    state_d = S_FAIL;
                    code_d  = CODE_RANGE;
                end else begin
                    state_d = S_WSETUP;
                    idx_d   = 2'd0;
                end
            end
            S_WSETUP: begin
                if (abort) begin
                    state_d = S_FAIL;
                    code_d  = CODE_ABORT;
                end else begin
                    state_d = S_WSTROBE;
                end
            end
            S_WSTROBE: begin
                if (abort) begin
                    state_d = S_FAIL;
                    code_d  = CODE_ABORT;
                end else if (idx_q == 2'd3) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_WSETUP;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_FAIL;
                    code_d  = CODE_ABORT;
                end else if (cnt_err) begin
                    state_d = S_FAIL;
                    code_d  = CODE_RANGE;
                end else begin
                    state_d     = S_START;
                    start_cnt_d = 4'd0;
                end
            end
            S_START: begin
                if (abort) begin
                    state_d = S_FAIL;
                    code_d  = CODE_ABORT;
                end else if (start_cnt_q == 4'(START_W - 1)) begin
                    state_d  = S_RUN;
                    to_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                // End-of-cycle wins over abort, which wins over err and timeout.
                if (cnt_ec) begin
                    state_d = S_DONE;
                end else if (abort) begin
                    state_d = S_FAIL;
                    code_d  = CODE_ABORT;
                end else if (cnt_err) begin
                    state_d = S_FAIL;
                    code_d  = CODE_RANGE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_FAIL;
                    code_d  = CODE_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state. Address and data come from the
    // upcoming write index, so they change only on a setup cycle. nwr is high
    // during that cycle.
    always_comb begin
        case (idx_d)
            2'd0:    wr_data = plr_q;
            2'd1:    wr_data = ulr_q;
            2'd2:    wr_data = llr_q;
            default: wr_data = ccr_q;
        endcase

        ncs_d   = 1'b1;
        nwr_d   = 1'b1;
        addr_d  = 2'd0;
        dout_d  = 8'd0;
        oe_d    = 1'b0;
        start_d = 1'b0;

        case (state_d)
            S_WSETUP: begin
                ncs_d  = 1'b0;
                addr_d = idx_d;
                dout_d = wr_data;
                oe_d   = 1'b1;
            end
            S_WSTROBE: begin
                ncs_d  = 1'b0;
                nwr_d  = 1'b0;
                addr_d = idx_d;
                dout_d = wr_data;
                oe_d   = 1'b1;
            end
            S_CHECK, S_RUN: ncs_d = 1'b0;
            S_START: begin
                ncs_d   = 1'b0;
                start_d = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        fail_d = (state_d == S_FAIL);
    end

    // State and output registers. Reset is asynchronous, so the bus drops to
    // its inactive levels at once, even in the middle of a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            plr_q       <= 8'd0;
            ulr_q       <= 8'd0;
            llr_q       <= 8'd0;
            ccr_q       <= 8'd0;
            idx_q       <= 2'd0;
            start_cnt_q <= 4'd0;
            to_cnt_q    <= '0;
            ncs_q       <= 1'b1;
            nwr_q       <= 1'b1;
            addr_q      <= 2'd0;
            dout_q      <= 8'd0;
            oe_q        <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            code_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            plr_q       <= plr_d;
            ulr_q       <= ulr_d;
            llr_q       <= llr_d;
            ccr_q       <= ccr_d;
            idx_q       <= idx_d;
            start_cnt_q <= start_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ncs_q       <= ncs_d;
            nwr_q       <= nwr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            code_q      <= code_d;
        end
    end

    assign ncs       = ncs_q;
    assign nwr       = nwr_q;
    assign nrd       = 1'b1;
    assign a1        = addr_q[1];
    assign a0        = addr_q[0];
    assign bus_dout  = dout_q;
    assign bus_oe    = oe_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = code_q;

endmodule
